// File: rtl/pong2_pkg.sv
// Shared types, colours and ball sprite for the two-player pong pixel generator.
package pong2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    OVER
  } state_t;

  localparam int PADDLE_WIDTH = 4;
  localparam int BALL_SIZE    = 8;

  localparam logic [11:0] COL_OFF    = 12'h000;
  localparam logic [11:0] COL_PADDLE = 12'hAAA;
  localparam logic [11:0] COL_BALL   = 12'hFFF;
  localparam logic [11:0] COL_NET    = 12'h555;
  localparam logic [11:0] COL_BG     = 12'h111;

  // Round ball sprite, one row per call; MSB is the leftmost pixel.
  function automatic logic [7:0] ball_rom(input logic [2:0] row);
    case (row)
      3'd0, 3'd7: return 8'h3C;
      3'd1, 3'd6: return 8'h7E;
      default:    return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/pong2_paddle.sv
// One vertical paddle: moves by VELOCITY per frame tick, clamped inside the table.
module pong2_paddle #(
  parameter int HEIGHT       = 30,
  parameter int VELOCITY     = 4,
  parameter int TABLE_HEIGHT = 120,
  parameter int Y_BIT_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   up,
  input  logic                   down,
  input  logic                   freeze,
  output logic [Y_BIT_WIDTH-1:0] top
);

  localparam logic [Y_BIT_WIDTH-1:0] TOP_INIT = Y_BIT_WIDTH'((TABLE_HEIGHT - HEIGHT) / 2);
  localparam logic [Y_BIT_WIDTH-1:0] VEL      = Y_BIT_WIDTH'(VELOCITY);
  // Largest top that can still step down without the bottom edge leaving the table.
  localparam logic [Y_BIT_WIDTH-1:0] TOP_MAX  = Y_BIT_WIDTH'(TABLE_HEIGHT - HEIGHT - VELOCITY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      top <= TOP_INIT;
    end else if (tick && !freeze) begin
      if (up && !down && top >= VEL) begin
        top <= top - VEL;
      end else if (down && !up && top <= TOP_MAX) begin
        top <= top + VEL;
      end
    end
  end

endmodule

// File: rtl/pong2_pixel_gen.sv
// Two-player pong pixel generator: paddles, round ball, net, scores and game FSM.
// Build macro PONG_CPU_PADDLE_EN makes the left paddle chase the ball instead of up_l/down_l.
//
// state | meaning
// IDLE  | ball centred and hidden, waiting for start
// SERVE | countdown before the ball is released
// PLAY  | ball moving; bounces and misses evaluated each frame
// POINT | ball recentred; pause, or end of game if a score reached WIN_SCORE
// OVER  | winner decided, everything frozen until start
module pong2_pixel_gen
  import pong2_pkg::*;
#(
  parameter int TABLE_WIDTH     = 160,
  parameter int TABLE_HEIGHT    = 120,
  parameter int PADDLE_HEIGHT   = 30,
  parameter int PADDLE_VELOCITY = 4,
  parameter int BALL_SPEED      = 2,
  parameter int WIN_SCORE       = 7,
  parameter int SERVE_FRAMES    = 60,
  parameter int SCORE_WIDTH     = 4,
  parameter int X_BIT_WIDTH     = 10,
  parameter int Y_BIT_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   up_l,
  input  logic                   down_l,
  input  logic                   up_r,
  input  logic                   down_r,
  input  logic                   video_on,
  input  logic [X_BIT_WIDTH-1:0] x,
  input  logic [Y_BIT_WIDTH-1:0] y,
  output logic [11:0]            rgb,
  output logic [SCORE_WIDTH-1:0] score_l,
  output logic [SCORE_WIDTH-1:0] score_r,
  output logic                   game_over,
  output logic                   winner
);

  localparam int XW = X_BIT_WIDTH;
  localparam int YW = Y_BIT_WIDTH;
  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [XW-1:0] LP_L     = XW'(TABLE_WIDTH / 20);
  localparam logic [XW-1:0] LP_R     = XW'(TABLE_WIDTH / 20 + PADDLE_WIDTH - 1);
  localparam logic [XW-1:0] RP_L     = XW'(TABLE_WIDTH - TABLE_WIDTH / 20 - PADDLE_WIDTH);
  localparam logic [XW-1:0] RP_R     = XW'(TABLE_WIDTH - TABLE_WIDTH / 20 - 1);
  localparam logic [XW-1:0] NET_X    = XW'(TABLE_WIDTH / 2);
  localparam logic [XW-1:0] BALL_X0  = XW'((TABLE_WIDTH - BALL_SIZE) / 2);
  localparam logic [YW-1:0] BALL_Y0  = YW'((TABLE_HEIGHT - BALL_SIZE) / 2);
  localparam logic [XW-1:0] BALL_MX  = XW'(BALL_SIZE - 1);
  localparam logic [YW-1:0] BALL_MY  = YW'(BALL_SIZE - 1);
  localparam logic [XW-1:0] SX       = XW'(BALL_SPEED);
  localparam logic [YW-1:0] SY       = YW'(BALL_SPEED);
  localparam logic [XW-1:0] X_MISS_R = XW'(TABLE_WIDTH - 1 - BALL_SPEED);
  localparam logic [YW-1:0] Y_BOT    = YW'(TABLE_HEIGHT - 1 - BALL_SPEED);
  localparam logic [YW-1:0] TICK_Y   = YW'(TABLE_HEIGHT + 1);
  localparam logic [YW-1:0] PH_M1    = YW'(PADDLE_HEIGHT - 1);
  localparam logic signed [XW-1:0] DX_POS = XW'(BALL_SPEED);
  localparam logic signed [XW-1:0] DX_NEG = -DX_POS;
  localparam logic signed [YW-1:0] DY_POS = YW'(BALL_SPEED);
  localparam logic signed [YW-1:0] DY_NEG = -DY_POS;
  localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SCORE_WIDTH-1:0] WIN = SCORE_WIDTH'(WIN_SCORE);

  state_t                state;
  logic [XW-1:0]         ball_x, ball_r;
  logic [YW-1:0]         ball_y, ball_b;
  logic signed [XW-1:0]  dx, dx_n;
  logic signed [YW-1:0]  dy, dy_n;
  logic [CW-1:0]         cnt;
  logic [YW-1:0]         top_l, top_r;
  logic                  refresh_tick, freeze, paddle_rst_n;
  logic                  up_l_eff, down_l_eff;
  logic                  hit_l, hit_r, miss_l, miss_r;
  logic                  pad_on, ball_on, net_on;
  logic [2:0]            rom_row, rom_col;
  logic [7:0]            rom_bits;

  assign refresh_tick = (y == TICK_Y) && (x == '0);
  assign freeze       = (state == OVER);
  // Restart from OVER recentres both paddles through their own synchronous reset.
  assign paddle_rst_n = reset_n && !(refresh_tick && freeze && start);

`ifdef PONG_CPU_PADDLE_EN
  localparam logic [YW-1:0] VEL = YW'(PADDLE_VELOCITY);
  logic [YW-1:0] pad_c, ball_c;
  logic          cpu_act;
  assign pad_c      = top_l + YW'(PADDLE_HEIGHT / 2);
  assign ball_c     = ball_y + YW'(BALL_SIZE / 2);
  assign cpu_act    = (state == SERVE) || (state == PLAY);
  assign up_l_eff   = cpu_act && (pad_c > ball_c + VEL);
  assign down_l_eff = cpu_act && (ball_c > pad_c + VEL);
`else
  assign up_l_eff   = up_l;
  assign down_l_eff = down_l;
`endif

  pong2_paddle #(
    .HEIGHT(PADDLE_HEIGHT), .VELOCITY(PADDLE_VELOCITY),
    .TABLE_HEIGHT(TABLE_HEIGHT), .Y_BIT_WIDTH(YW)
  ) u_paddle_l (
    .clk(clk), .reset_n(paddle_rst_n), .tick(refresh_tick),
    .up(up_l_eff), .down(down_l_eff), .freeze(freeze), .top(top_l)
  );

  pong2_paddle #(
    .HEIGHT(PADDLE_HEIGHT), .VELOCITY(PADDLE_VELOCITY),
    .TABLE_HEIGHT(TABLE_HEIGHT), .Y_BIT_WIDTH(YW)
  ) u_paddle_r (
    .clk(clk), .reset_n(paddle_rst_n), .tick(refresh_tick),
    .up(up_r), .down(down_r), .freeze(freeze), .top(top_r)
  );

  assign ball_r = ball_x + BALL_MX;
  assign ball_b = ball_y + BALL_MY;
  assign hit_l  = (ball_r >= LP_L) && (ball_x <= LP_R) && (ball_b >= top_l) && (ball_y <= top_l + PH_M1);
  assign hit_r  = (ball_r >= RP_L) && (ball_x <= RP_R) && (ball_b >= top_r) && (ball_y <= top_r + PH_M1);
  assign miss_l = (ball_x <= SX) && !hit_l;
  assign miss_r = (ball_r >= X_MISS_R) && !hit_r;

  always_comb begin
    dx_n = dx;
    dy_n = dy;
    if (ball_y <= SY)       dy_n = DY_POS;
    else if (ball_b >= Y_BOT) dy_n = DY_NEG;
    if (hit_r)              dx_n = DX_NEG;
    else if (hit_l)         dx_n = DX_POS;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx        <= DX_POS;
      dy        <= DY_POS;
      cnt       <= '0;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (refresh_tick) begin
      unique case (state)
        IDLE: if (start) begin
          state <= SERVE;
          cnt   <= CNT_INIT;
        end
        SERVE: if (cnt <= CNT_ONE) begin
          state <= PLAY;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
        PLAY: begin
          dx <= dx_n;
          dy <= dy_n;
          if (miss_l || miss_r) begin
            state  <= POINT;
            cnt    <= CNT_INIT;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            if (miss_l) begin
              score_r <= (score_r == WIN) ? score_r : score_r + 1'b1;
              dx      <= DX_NEG;
            end else begin
              score_l <= (score_l == WIN) ? score_l : score_l + 1'b1;
              dx      <= DX_POS;
            end
          end else begin
            ball_x <= ball_x + $unsigned(dx_n);
            ball_y <= ball_y + $unsigned(dy_n);
          end
        end
        POINT: if (score_l == WIN || score_r == WIN) begin
          state     <= OVER;
          game_over <= 1'b1;
          winner    <= (score_r == WIN);
        end else if (cnt <= CNT_ONE) begin
          state <= SERVE;
          cnt   <= CNT_INIT;
        end else begin
          cnt <= cnt - 1'b1;
        end
        OVER: if (start) begin
          state     <= SERVE;
          cnt       <= CNT_INIT;
          score_l   <= '0;
          score_r   <= '0;
          ball_x    <= BALL_X0;
          ball_y    <= BALL_Y0;
          dx        <= DX_POS;
          dy        <= DY_POS;
          game_over <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_row  = y[2:0] - ball_y[2:0];
  assign rom_col  = x[2:0] - ball_x[2:0];
  assign rom_bits = ball_rom(rom_row);
  assign pad_on   = (x >= LP_L && x <= LP_R && y >= top_l && y <= top_l + PH_M1) ||
                    (x >= RP_L && x <= RP_R && y >= top_r && y <= top_r + PH_M1);
  assign ball_on  = (state != IDLE) && (x >= ball_x) && (x <= ball_r) &&
                    (y >= ball_y) && (y <= ball_b) && rom_bits[3'd7 - rom_col];
  assign net_on   = (x == NET_X) && !y[3];

  always_ff @(posedge clk) begin
    if (!reset_n)      rgb <= COL_OFF;
    else if (!video_on) rgb <= COL_OFF;
    else if (pad_on)   rgb <= COL_PADDLE;
    else if (ball_on)  rgb <= COL_BALL;
    else if (net_on)   rgb <= COL_NET;
    else               rgb <= COL_BG;
  end

endmodule
